panda_regfile_sb: RTL and testbench

Multi-port integer register file with write-first bypass and a per-register busy scoreboard, for dual-issue and out-of-order-writeback configurations of the Panda core. It sits between decode/issue and the writeback stage. Issue reserves destinations, and writeback ports retire them. Read ports return bypassed data and a busy flag that lets issue stall on RAW hazards.

---
 rtl/panda_regfile_sb.sv | 145 ++++++++++++++
 tb/tb_panda_regfile_sb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_regfile_sb.sv
// -----------------------------------------------------------------------------
// panda_regfile_sb
//
// Multi-port integer register file with a per-register busy scoreboard.
// Issue reserves destinations. Writeback ports write data and retire
// those reservations. Read ports return write-first bypassed data and a
// busy flag that issue uses to stall on RAW hazards.
//
// Parameters
//   Width     data bits per register
//   Depth     number of architectural registers
//   NumRead   number of read ports  (1..8)
//   NumWrite  number of write ports (1..4)
//   ZeroReg   1: register 0 reads as zero, is never written, never busy
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_ni       synchronous active-low reset; clears regs and busy bits
//   rs_addr_i    per read port: register address
//   rs_data_o    per read port: bypassed read data (combinational)
//   rs_busy_o    per read port: outstanding reservation not satisfied by a
//                write in this cycle (combinational)
//   rd_addr_i    per write port: destination address
//   rd_data_i    per write port: write data
//   rd_we_i      per write port: write enable
//   rsv_addr_i   destination to reserve
//   rsv_valid_i  reserve request
//   flush_i      clear every busy bit; register contents are kept
// -----------------------------------------------------------------------------
module panda_regfile_sb #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 32,
  parameter int unsigned NumRead  = 2,
  parameter int unsigned NumWrite = 2,
  parameter bit          ZeroReg  = 1'b1,
  localparam int unsigned AddrW   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumRead-1:0][AddrW-1:0]    rs_addr_i,
  output logic [NumRead-1:0][Width-1:0]    rs_data_o,
  output logic [NumRead-1:0]               rs_busy_o,
  input  logic [NumWrite-1:0][AddrW-1:0]   rd_addr_i,
  input  logic [NumWrite-1:0][Width-1:0]   rd_data_i,
  input  logic [NumWrite-1:0]              rd_we_i,
  input  logic [AddrW-1:0]                 rsv_addr_i,
  input  logic                             rsv_valid_i,
  input  logic                             flush_i
);

  // An address holds real state only when it is inside the array and is not
  // the hardwired zero register. The widening cast keeps the range compare
  // meaningful when Depth is not a power of two.
  function automatic logic is_live(input logic [AddrW-1:0] addr);
    return (32'(addr) < Depth) && !(ZeroReg && (addr == '0));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [Width-1:0] regs_q [Depth];
  logic [Width-1:0] regs_d [Depth];
  logic [Depth-1:0] busy_q;
  logic [Depth-1:0] busy_d;

  // Per-register view of this cycle's writeback traffic. wr_data holds the
  // value of the highest-indexed port that targets the register.
  logic [Depth-1:0] wr_hit;
  logic [Width-1:0] wr_data [Depth];

  // ---------------------------------------------------------------------------
  // Write decode: one comparator per (register, port) pair. Walking the ports
  // in ascending order lets the highest-indexed port overwrite earlier ones.
  // ---------------------------------------------------------------------------
  always_comb begin : write_decode
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    wr_hit = '0;
    for (int a = 0; a < Depth; a++) begin
      wr_data[a] = '0;
      for (int p = 0; p < NumWrite; p++) begin
        if (rd_we_i[p] && (rd_addr_i[p] == AddrW'(a)) && is_live(rd_addr_i[p])) begin
          wr_hit[a]  = 1'b1;
          wr_data[a] = rd_data_i[p];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for the array and the scoreboard.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    for (int a = 0; a < Depth; a++) begin
      regs_d[a] = wr_hit[a] ? wr_data[a] : regs_q[a];
    end

    if (flush_i) begin
      // A flush squashes everything in flight, including a reserve issued in
      // the same cycle.
      busy_d = '0;
    end else begin
      // Writeback retires reservations; a same-cycle reserve belongs to a
      // younger instruction, so it is applied last and wins.
      busy_d = busy_q & ~wr_hit;
      if (rsv_valid_i && is_live(rsv_addr_i)) begin
        busy_d[rsv_addr_i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin : state_regs
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_ni) begin
      // NOTE: the register array is reset deliberately: software may read any
      // register after reset and must see zero, so the reset cost is accepted.
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: write-first bypass over the array, busy masked by a write
  // that satisfies the hazard in the same cycle. Dead addresses read zero.
  // ---------------------------------------------------------------------------
  always_comb begin : read_ports
    for (int r = 0; r < NumRead; r++) begin
      rs_data_o[r] = '0;
      rs_busy_o[r] = 1'b0;
      if (is_live(rs_addr_i[r])) begin
        rs_data_o[r] = wr_hit[rs_addr_i[r]] ? wr_data[rs_addr_i[r]]
                                            : regs_q[rs_addr_i[r]];
        rs_busy_o[r] = busy_q[rs_addr_i[r]] && !wr_hit[rs_addr_i[r]];
      end
    end
  end

endmodule

// File: tb/tb_panda_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_panda_regfile_sb
//
// Self-checking bench for panda_regfile_sb with default parameters. A
// behavioural model (plain arrays of register values and busy flags) is
// updated at each rising edge from the inputs the DUT sampled; a compare
// process checks every read port on every falling edge. Directed scenarios
// pin the model with literal expectations, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_panda_regfile_sb;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int D  = 32;
  localparam int AW = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NR-1:0][AW-1:0]    rs_addr;
  logic [NR-1:0][31:0]      rs_data;
  logic [NR-1:0]            rs_busy;
  logic [NW-1:0][AW-1:0]    rd_addr;
  logic [NW-1:0][31:0]      rd_data;
  logic [NW-1:0]            rd_we;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_valid;
  logic                     flush;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference state
  logic [31:0] m_regs [D];
  bit          m_busy [D];

  panda_regfile_sb #(
    .Width(32), .Depth(D), .NumRead(NR), .NumWrite(NW), .ZeroReg(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rs_addr_i  (rs_addr),
    .rs_data_o  (rs_data),
    .rs_busy_o  (rs_busy),
    .rd_addr_i  (rd_addr),
    .rd_data_i  (rd_data),
    .rd_we_i    (rd_we),
    .rsv_addr_i (rsv_addr),
    .rsv_valid_i(rsv_valid),
    .flush_i    (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: what a read port must show given the architectural state and the
  // writes presented this cycle.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] m_read(input int unsigned a);
    if (a == 0) return 32'h0;
    for (int p = NW - 1; p >= 0; p--)
      if (rd_we[p] && (int'(rd_addr[p]) == a)) return rd_data[p];
    return m_regs[a];
  endfunction

  function automatic bit m_read_busy(input int unsigned a);
    if (a == 0) return 1'b0;
    for (int p = 0; p < NW; p++)
      if (rd_we[p] && (int'(rd_addr[p]) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Architectural update at a rising edge from the sampled inputs.
  function automatic void m_update();
    if (!rst_n) begin
      for (int a = 0; a < D; a++) begin
        m_regs[a] = '0;
        m_busy[a] = 1'b0;
      end
      return;
    end
    for (int p = 0; p < NW; p++) begin
      if (rd_we[p] && rd_addr[p] != 0) begin
        m_regs[rd_addr[p]] = rd_data[p];
        m_busy[rd_addr[p]] = 1'b0;
      end
    end
    if (flush) begin
      for (int a = 0; a < D; a++) m_busy[a] = 1'b0;
    end else if (rsv_valid && rsv_addr != 0) begin
      m_busy[rsv_addr] = 1'b1;
    end
  endfunction

  // Compare process: every read port, every cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int r = 0; r < NR; r++) begin
        check($sformatf("model_data_p%0d_x%0d", r, rs_addr[r]), rs_data[r], m_read(rs_addr[r]));
        check($sformatf("model_busy_p%0d_x%0d", r, rs_addr[r]), 32'(rs_busy[r]),
              32'(m_read_busy(rs_addr[r])));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    rd_we     = '0;
    rd_addr   = '0;
    rd_data   = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rs_addr = '0;
    idle();
    for (int a = 0; a < D; a++) begin
      m_regs[a] = 'x;
      m_busy[a] = 1'b0;
    end

    // Reset, held for two edges
    cycle();
    cmp_en = 1'b1;
    cycle();
    check("reset_held_data", rs_data[0], 32'h0);
    check("reset_held_busy", 32'(rs_busy[1]), 32'h0);
    rst_n = 1'b1;

    // Every address on every port reads zero / not busy after reset
    for (int a = 0; a < D; a++) begin
      for (int r = 0; r < NR; r++) rs_addr[r] = AW'(a);
      #1;
      for (int r = 0; r < NR; r++) begin
        check($sformatf("rst_data_p%0d_x%0d", r, a), rs_data[r], 32'h0);
        check($sformatf("rst_busy_p%0d_x%0d", r, a), 32'(rs_busy[r]), 32'h0);
      end
      cycle();
    end

    // x0 is hardwired
    rd_we[0] = 1'b1; rd_addr[0] = 5'd0; rd_data[0] = 32'hDEADBEEF;
    rs_addr[0] = 5'd0; rs_addr[1] = 5'd0;
    #1 check("x0_bypass", rs_data[0], 32'h0);
    cycle(); idle();
    #1 check("x0_after_write", rs_data[1], 32'h0);

    // Same-cycle bypass, then array
    rd_we[0] = 1'b1; rd_addr[0] = 5'd5; rd_data[0] = 32'h12345678;
    rs_addr[0] = 5'd5;
    #1 check("bypass_x5", rs_data[0], 32'h12345678);
    cycle(); idle();
    #1 check("array_x5", rs_data[0], 32'h12345678);

    // Port priority
    rd_we = 2'b11;
    rd_addr[0] = 5'd7; rd_data[0] = 32'h1;
    rd_addr[1] = 5'd7; rd_data[1] = 32'h2;
    rs_addr[1] = 5'd7;
    #1 check("prio_bypass_x7", rs_data[1], 32'h2);
    cycle(); idle();
    #1 check("prio_array_x7", rs_data[1], 32'h2);

    // Scoreboard flow on x9
    rsv_valid = 1'b1; rsv_addr = 5'd9; rs_addr[0] = 5'd9;
    #1 check("rsv_c0_busy", 32'(rs_busy[0]), 32'h0);
    cycle(); idle();
    #1 check("rsv_c1_busy", 32'(rs_busy[0]), 32'h1);
    cycle();
    #1 check("rsv_c2_busy", 32'(rs_busy[0]), 32'h1);
    cycle();
    rd_we[1] = 1'b1; rd_addr[1] = 5'd9; rd_data[1] = 32'hAA;
    #1 check("wb_c3_busy", 32'(rs_busy[0]), 32'h0);
    check("wb_c3_data", rs_data[0], 32'hAA);
    cycle(); idle();
    #1 check("wb_c4_busy", 32'(rs_busy[0]), 32'h0);
    check("wb_c4_data", rs_data[0], 32'hAA);

    // Reserve and write x9 together: reservation survives, data updates
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    rd_we[0] = 1'b1; rd_addr[0] = 5'd9; rd_data[0] = 32'h55;
    cycle(); idle();
    #1 check("rsv_wr_busy", 32'(rs_busy[0]), 32'h1);
    check("rsv_wr_data", rs_data[0], 32'h55);

    // Flush clears busy bits, keeps contents
    rd_we = 2'b11;
    rd_addr[0] = 5'd3; rd_data[0] = 32'h33;
    rd_addr[1] = 5'd4; rd_data[1] = 32'h44;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    cycle(); idle();
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    cycle(); idle();
    rs_addr[0] = 5'd3; rs_addr[1] = 5'd4;
    #1 check("pre_flush_x3", 32'(rs_busy[0]), 32'h1);
    check("pre_flush_x4", 32'(rs_busy[1]), 32'h1);
    flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1 check("flush_cycle_x3", 32'(rs_busy[0]), 32'h1);
    cycle(); idle();
    #1 check("post_flush_x3", 32'(rs_busy[0]), 32'h0);
    check("post_flush_x4", 32'(rs_busy[1]), 32'h0);
    check("post_flush_d3", rs_data[0], 32'h33);
    check("post_flush_d4", rs_data[1], 32'h44);

    // Reset mid-operation with writes and a reserve in flight
    rst_n = 1'b0;
    rd_we = 2'b11;
    rd_addr[0] = 5'd10; rd_data[0] = 32'h1010;
    rd_addr[1] = 5'd11; rd_data[1] = 32'h1111;
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    cycle(); idle();
    rst_n = 1'b1;
    rs_addr[0] = 5'd10; rs_addr[1] = 5'd5;
    #1 check("mid_rst_x10", rs_data[0], 32'h0);
    check("mid_rst_x5", rs_data[1], 32'h0);
    rs_addr[0] = 5'd12; rs_addr[1] = 5'd11;
    #1 check("mid_rst_busy_x12", 32'(rs_busy[0]), 32'h0);
    check("mid_rst_x11", rs_data[1], 32'h0);
    rd_we[0] = 1'b1; rd_addr[0] = 5'd10; rd_data[0] = 32'h77;
    cycle(); idle();
    rs_addr[0] = 5'd10;
    #1 check("resume_x10", rs_data[0], 32'h77);

    // Randomized traffic; narrow address window half the time for collisions
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int p = 0; p < NW; p++) begin
        rd_we[p]   = ($urandom_range(0, 2) == 0);
        rd_addr[p] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D - 1));
        rd_data[p] = $urandom;
      end
      for (int r = 0; r < NR; r++)
        rs_addr[r] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D - 1));
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D - 1));
      flush     = ($urandom_range(0, 29) == 0);
      cycle();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
